// File: rtl/fifo_burst_pkg.sv
// Shared types, widths and helpers for the FIFO burst reader.
// Optional build macro for the whole slice: FIFO_BURST_STATS_EN.
package fifo_burst_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    localparam int unsigned DEF_BURST_LEN = 32'd8;
    localparam int unsigned DEF_TIMEOUT   = 32'd16;

    // Widths for the default configuration; the top recomputes them from its own parameters.
    localparam int unsigned CNT_W = $clog2(DEF_BURST_LEN + 32'd1);
    localparam int unsigned TMR_W = (DEF_TIMEOUT == 32'd0) ? 32'd1 : $clog2(DEF_TIMEOUT + 32'd1);

    function automatic int unsigned cnt_width(input int unsigned burst);
        return $clog2(burst + 32'd1);
    endfunction

    function automatic int unsigned tmr_width(input int unsigned timeout);
        return (timeout == 32'd0) ? 32'd1 : $clog2(timeout + 32'd1);
    endfunction

    function automatic int unsigned min_count(input int unsigned count, input int unsigned burst);
        return (count < burst) ? count : burst;
    endfunction

endpackage

// File: rtl/fifo_burst_skid.sv
// Two-entry valid/ready skid buffer holding FIFO read data until the stream accepts it.
module fifo_burst_skid
    import fifo_burst_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop_s;

    assign pop_s   = pop_i && (occ_q != 2'd0);
    assign head_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;

    // Next-state of the two entries; the tail shifts into the head on every pop.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO in bursts onto a valid/ready stream, flushing partial bursts on timeout.
// Optional build macro: FIFO_BURST_STATS_EN adds burst_cnt / partial_cnt completion counters.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned POINTER_WIDTH = $clog2(DEPTH),
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fifo_empty,
    input  logic [POINTER_WIDTH:0] fifo_count,
    input  logic [WIDTH-1:0]       fifo_rd_data,
    output logic                   fifo_read_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_last,
    output logic                   busy
`ifdef FIFO_BURST_STATS_EN
    ,
    output logic [15:0]            burst_cnt,
    output logic [15:0]            partial_cnt
`endif
);

    // An out-of-range burst length is clamped to the FIFO depth.
    localparam int unsigned BURST_EFF = min_count(BURST_LEN, DEPTH);
    localparam int unsigned REM_W     = cnt_width(BURST_EFF);
    localparam int unsigned TIM_W     = tmr_width(TIMEOUT);

    localparam logic [POINTER_WIDTH:0] BURST_C   = (POINTER_WIDTH + 1)'(BURST_EFF);
    localparam logic [REM_W-1:0]       BURST_R   = REM_W'(BURST_EFF);
    localparam logic [TIM_W-1:0]       TIMEOUT_C = TIM_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [REM_W-1:0] issue_q, issue_d;
    logic [REM_W-1:0] send_q, send_d;
    logic [TIM_W-1:0] timer_q, timer_d;
    logic             inflight_q;

    logic [WIDTH-1:0] skid_head_s;
    logic             skid_valid_s;
    logic [1:0]       skid_occ_s;
    logic             hs_s;
    logic             last_s;
    logic             rd_s;
    logic [2:0]       pending_s;
    logic [REM_W-1:0] partial_len_s;

    assign hs_s          = skid_valid_s && m_ready;
    assign last_s        = skid_valid_s && (send_q == REM_W'(1));
    assign partial_len_s = REM_W'(min_count(32'(fifo_count), BURST_EFF));

    // A word popped this cycle frees its slot, so reads keep streaming at one per cycle.
    assign pending_s = 3'(skid_occ_s) - 3'(hs_s) + 3'(inflight_q);
    assign rd_s      = (state_q == READ) && (issue_q != '0) && !fifo_empty && (pending_s < 3'd2);

    assign fifo_read_en = rd_s;
    assign m_valid      = skid_valid_s;
    assign m_data       = skid_head_s;
    assign m_last       = last_s;
    assign busy         = (state_q == READ);

    fifo_burst_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_rd_data),
        .pop_i       (hs_s),
        .head_o      (skid_head_s),
        .valid_o     (skid_valid_s),
        .occ_o       (skid_occ_s)
    );

    // Burst FSM next-state, idle timer and issue/send counters.
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        send_d  = send_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (fifo_count >= BURST_C) begin
                    state_d = READ;
                    issue_d = BURST_R;
                    send_d  = BURST_R;
                    timer_d = '0;
                end else if ((TIMEOUT != 32'd0) && (fifo_count != '0) && (timer_q == TIMEOUT_C)) begin
                    state_d = READ;
                    issue_d = partial_len_s;
                    send_d  = partial_len_s;
                    timer_d = '0;
                end else if (fifo_count == '0) begin
                    timer_d = '0;
                end else if (timer_q != TIMEOUT_C) begin
                    timer_d = timer_q + TIM_W'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            READ: begin
                timer_d = '0;
                if (rd_s) begin
                    issue_d = issue_q - REM_W'(1);
                end else begin
                    issue_d = issue_q;
                end
                if (hs_s) begin
                    send_d = send_q - REM_W'(1);
                    if (last_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    send_d = send_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; a read still in flight at reset is dropped with inflight_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            send_q     <= '0;
            timer_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            send_q     <= send_d;
            timer_q    <= timer_d;
            inflight_q <= rd_s;
        end
    end

`ifdef FIFO_BURST_STATS_EN
    logic        partial_q;
    logic [15:0] burst_cnt_q;
    logic [15:0] partial_cnt_q;

    assign burst_cnt   = burst_cnt_q;
    assign partial_cnt = partial_cnt_q;

    // Remember how the current burst was started and count it when its last word leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            partial_q     <= 1'b0;
            burst_cnt_q   <= 16'd0;
            partial_cnt_q <= 16'd0;
        end else begin
            if ((state_q == IDLE) && (state_d == READ)) begin
                partial_q <= (fifo_count < BURST_C);
            end else begin
                partial_q <= partial_q;
            end
            if (hs_s && last_s) begin
                if (partial_q) begin
                    partial_cnt_q <= partial_cnt_q + 16'd1;
                end else begin
                    burst_cnt_q <= burst_cnt_q + 16'd1;
                end
            end else begin
                burst_cnt_q <= burst_cnt_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed scoreboard bench for fifo_burst_reader with a behavioural FIFO on the read side.
module tb_fifo_burst_reader;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int PW    = 5;
    localparam int BL    = 8;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             m_ready = 1'b1;
    logic             fifo_empty = 1'b1;
    logic [PW:0]      fifo_count = '0;
    logic [WIDTH-1:0] fifo_rd_data = '0;
    logic             fifo_read_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
`ifdef FIFO_BURST_STATS_EN
    logic [15:0]      burst_cnt;
    logic [15:0]      partial_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] pend[$];
    logic [WIDTH:0]   sb[$];
    int               reads_issued = 0;
    int               accepted     = 0;
    logic             prev_stall   = 1'b0;
    logic [WIDTH-1:0] prev_data    = '0;
    logic [WIDTH:0]   exp_w;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DEPTH         (DEPTH),
        .WIDTH         (WIDTH),
        .POINTER_WIDTH (PW),
        .BURST_LEN     (BL),
        .TIMEOUT       (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .fifo_rd_data (fifo_rd_data),
        .fifo_read_en (fifo_read_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy)
`ifdef FIFO_BURST_STATS_EN
        ,
        .burst_cnt    (burst_cnt),
        .partial_cnt  (partial_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, expv);
        end
    endtask

    // Behavioural FIFO: pops on read strobe, data valid the following cycle, new words land at the edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            fq.delete();
            pend.delete();
            reads_issued = 0;
        end else if (fifo_read_en) begin
            chk("no_underflow", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) fifo_rd_data <= fq.pop_front();
            reads_issued++;
        end
        while (pend.size() != 0) fq.push_back(pend.pop_front());
        fifo_count <= (PW + 1)'(fq.size());
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor: scoreboard compare on handshake, hold-while-stalled and read-gating checks.
    always @(negedge clk) begin
        #2;
        if (reset_n) begin
            chk("rd_when_empty", 32'(fifo_read_en && fifo_empty), 32'd0);
            chk("outstanding_le2", 32'((reads_issued - accepted) <= 2), 32'd1);
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                chk("word_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    chk("m_data", 32'(m_data), 32'(exp_w[WIDTH-1:0]));
                    chk("m_last", 32'(m_last), 32'(exp_w[WIDTH]));
                end
                accepted++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
            accepted   = 0;
        end
    end

    task automatic fifo_push(input int base, input int n);
        for (int i = 0; i < n; i++) pend.push_back(WIDTH'(base + i));
    endtask

    task automatic expect_burst(input int base, input int n);
        for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), WIDTH'(base + i)});
    endtask

    task automatic wait_rd(input string tag, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            m_ready = 1'b1;
            #2;
            k++;
        end while (!fifo_read_en && k < budget);
        chk(tag, 32'(fifo_read_en), 32'd1);
    endtask

    task automatic drain(input string tag, input int budget, input bit toggle);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            m_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            #3;
            k++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        @(negedge clk);
        m_ready = 1'b1;
        #3;
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_read_en", 32'(fifo_read_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full burst, m_ready high: 8 back-to-back reads, first word two cycles after READ entry.
        fifo_push(8'h00, BL);
        expect_burst(8'h00, BL);
        wait_rd("t1_rd_start", 10);
        for (int i = 1; i < BL; i++) begin
            @(negedge clk);
            #2;
            chk("t1_rd_run", 32'(fifo_read_en), 32'd1);
            if (i == 1) chk("t1_no_valid_yet", 32'(m_valid), 32'd0);
            if (i == 2) chk("t1_first_valid", 32'(m_valid), 32'd1);
        end
        @(negedge clk);
        #2;
        chk("t1_rd_stop", 32'(fifo_read_en), 32'd0);
        drain("t1_drain", 50, 1'b0);

        // Partial burst: three words wait out the timeout before being read.
        fifo_push(8'h10, 3);
        expect_burst(8'h10, 3);
        for (int i = 0; i < TO + 1; i++) begin
            @(negedge clk);
            #2;
            chk("t2_no_early_rd", 32'(fifo_read_en), 32'd0);
        end
        @(negedge clk);
        #2;
        chk("t2_rd_after_timeout", 32'(fifo_read_en), 32'd1);
        drain("t2_drain", 50, 1'b0);
`ifdef FIFO_BURST_STATS_EN
        chk("t2_burst_cnt", 32'(burst_cnt), 32'd1);
        chk("t2_partial_cnt", 32'(partial_cnt), 32'd1);
`endif

        // Full burst with m_ready toggling 1,0,0,1.
        fifo_push(8'h20, BL);
        expect_burst(8'h20, BL);
        drain("t3_drain", 200, 1'b1);

        // Empty FIFO for 100 cycles: no reads, no output, timer idle.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #2;
            chk("t4_read_en", 32'(fifo_read_en), 32'd0);
            chk("t4_m_valid", 32'(m_valid), 32'd0);
            chk("t4_timer", 32'(dut.timer_q), 32'd0);
        end

        // Reset mid-burst after the fourth word has been accepted.
        fifo_push(8'h30, BL);
        expect_burst(8'h30, BL);
        begin
            int k = 0;
            while (sb.size() > BL - 4 && k < 50) begin
                @(negedge clk);
                #3;
                k++;
            end
            chk("t5_four_accepted", 32'(sb.size()), 32'(BL - 4));
        end
        reset_n = 1'b0;
        #1;
        chk("t5_rst_read_en", 32'(fifo_read_en), 32'd0);
        chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_m_data", 32'(m_data), 32'd0);
        chk("t5_rst_m_last", 32'(m_last), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fifo_push(8'h40, BL);
        expect_burst(8'h40, BL);
        wait_rd("t5_fresh_rd", 10);
        drain("t5_drain", 50, 1'b0);
`ifdef FIFO_BURST_STATS_EN
        chk("t5_burst_cnt", 32'(burst_cnt), 32'd1);
        chk("t5_partial_cnt", 32'(partial_cnt), 32'd0);
`endif

        // Count reaches BURST_LEN in the very cycle the timer reaches TIMEOUT: full burst wins.
        @(negedge clk);
        fifo_push(8'h50, 3);
        repeat (TO) @(negedge clk);
        fifo_push(8'h53, BL - 3);
        expect_burst(8'h50, BL);
        @(negedge clk);
        #2;
        chk("t6_timer_at_limit", 32'(dut.timer_q), 32'(TO));
        chk("t6_count_full", 32'(fifo_count), 32'(BL));
        drain("t6_drain", 50, 1'b0);
`ifdef FIFO_BURST_STATS_EN
        chk("t6_burst_cnt", 32'(burst_cnt), 32'd2);
        chk("t6_partial_cnt", 32'(partial_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side drain stage placed directly downstream of the synchronous FIFO.
- Watches FIFO occupancy and pulls words in bursts of BURST_LEN, driving fifo_read_en.
- Presents the words on a valid/ready stream with a last marker at the end of each burst.
- Flushes a partial burst after a programmable idle timeout, so trailing data is never stranded.
- Never asserts a read while the FIFO is empty.

Parameters:
- DEPTH, 32, FIFO depth in words.
- WIDTH, 8, data width in bits.
- POINTER_WIDTH, $clog2(DEPTH), FIFO pointer width. The count port is POINTER_WIDTH+1 bits.
- BURST_LEN, 8, words per full burst. Legal range is 1..DEPTH.
- TIMEOUT, 16, idle cycles before a partial burst is flushed. 0 disables partial flush.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  POINTER_WIDTH+1  FIFO occupancy, 0..DEPTH.
- fifo_rd_data  in  WIDTH  FIFO read data. Valid the cycle after a fifo_read_en cycle.
- fifo_read_en  out  1  FIFO pop strobe.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH  output word.
- m_last  out  1  asserted with the final word of each burst.
- busy  out  1  high while a burst is in progress.

Behaviour:
- Reset (async assert, sync release):
  - fifo_read_en=0, m_valid=0, m_data=0, m_last=0, busy=0.
  - FSM goes to IDLE; timer=0; skid buffer empty.
  - An in-flight FIFO read word is discarded.
- FSM IDLE:
  - If fifo_count>=BURST_LEN: latch remaining=BURST_LEN and go to READ.
  - Else if TIMEOUT!=0, fifo_count>0 and timer==TIMEOUT: latch remaining=fifo_count and go to READ. This is the partial burst.
  - timer increments each IDLE cycle while 0<fifo_count<BURST_LEN, saturating at TIMEOUT.
  - timer clears when fifo_count==0 or on leaving IDLE.
- FSM READ (busy=1):
  - Read condition: fifo_read_en = remaining_to_issue>0 && !fifo_empty && (skid_occupancy + inflight) < 2.
  - Each issued read decrements remaining_to_issue.
  - Returned data is written into a 2-entry skid buffer the following cycle.
- Output stream:
  - m_valid = skid buffer not empty; m_data = skid head.
  - m_last is 1 on the head word when it is the burst's final word (words_to_send==1).
  - Handshake occurs when m_valid && m_ready; the word pops and words_to_send decrements.
  - m_valid, once high, stays high and m_data stays stable until accepted.
  - Throughput is 1 word/cycle with m_ready held high. First m_valid comes 2 cycles after the READ entry cycle.
- READ -> IDLE happens on the handshake of the m_last word. busy drops the next cycle.
- A new burst may start in the cycle after returning to IDLE (minimum one bubble between bursts).
- Simultaneous events in IDLE: the full-burst check wins over the timeout. A full burst is taken even if the timer has expired.
- If the FIFO goes empty mid-burst (not possible with a sole reader): reads stall, with no underflow and no protocol error.
- Widths:
  - remaining and words_to_send are $clog2(BURST_LEN+1) bits.
  - timer is $clog2(TIMEOUT+1) bits (min 1).
  - fifo_count comparisons are unsigned at POINTER_WIDTH+1 bits.

Optional Feature:
- Macro: FIFO_BURST_STATS_EN.
- When defined, adds two outputs:
  - burst_cnt [15:0]: full bursts completed.
  - partial_cnt [15:0]: timeout bursts completed.
- Both increment on the m_last handshake, wrap at 16'hFFFF->0, and reset to 0.
- When undefined, neither port nor counter exists. Core behaviour is identical.

Decomposition:
- Package fifo_burst_pkg:
  - state enum {IDLE, READ}.
  - localparam widths CNT_W, TMR_W.
  - function min_count(count, burst).
- Sub-module fifo_burst_skid: 2-entry valid/ready buffer with an occupancy output, instantiated once.
- Top-level holds the FSM, timer and read gating.

Test Plan:
- fifo_count=8, BURST_LEN=8, m_ready=1: fifo_read_en high for 8 consecutive cycles, then 8 m_valid words with m_last on word 8, then busy=0.
- fifo_count=3 held, TIMEOUT=16: no read for 16 idle cycles, then 3 words are read; m_last on word 3; partial_cnt=1 with FIFO_BURST_STATS_EN.
- Full burst with m_ready toggling 1,0,0,1…: m_data stays stable while stalled, fifo_read_en stops once the skid holds 2 words, and no word is lost or duplicated (sequence 0..7 preserved).
- fifo_empty=1, fifo_count=0 for 100 cycles: fifo_read_en never asserts, m_valid=0, timer stays 0.
- reset_n pulsed low mid-burst after word 4: all outputs are 0 immediately. After release with fifo_count=8, a fresh 8-word burst starts.
- fifo_count reaches 8 in the same cycle the timer reaches TIMEOUT: a full 8-word burst is taken, burst_cnt increments and partial_cnt does not.
